// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin lock arbiter.
// Holds the FSM state enum and a one-hot encoder helper.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  // Returns a 16-bit vector with bit idx set (idx < n);
  // callers cast down to their own width.
  function automatic logic [15:0] onehot(
    input int idx,
    input int n
  );
    logic [15:0] v;
    v = '0;
    if (idx >= 0 && idx < n && idx < 16)
      v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of req from ptr upward, mod N.
// Ports: req[N], ptr[ID_W] in; any, winner[ID_W] out. Purely combinational.
module rr_pick #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            any,
  output logic [ID_W-1:0] winner
);

  assign any = |req;

  // Scan offsets high to low so the smallest offset from ptr wins.
  always_comb begin
    int j;
    j = 0;
    winner = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N)
        j = j - N;
      if (req[j])
        winner = ID_W'(j);
    end
  end

endmodule

// File: rtl/rr_lock_arbiter.sv
// N-way round-robin arbiter with grant locking and hold-time preemption.
// Ports: clock, reset (async high), req[N] in; gnt[N], gnt_id, busy, preempt out.
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 8,
  localparam int ID_W     = $clog2(N),
  localparam int HOLD_W   = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            preempt
);

  // Saturation point of the hold counter; unused when MAX_HOLD is 0.
  localparam logic [HOLD_W-1:0] HOLD_LIM =
    (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  arb_state_t        r_state;
  logic [N-1:0]      r_gnt;
  logic [ID_W-1:0]   r_gnt_id;
  logic              r_busy;
  logic              r_preempt;
  logic [ID_W-1:0]   r_ptr;
  logic [HOLD_W-1:0] r_hold;

  logic              w_any;
  logic [ID_W-1:0]   w_winner;
  logic [ID_W-1:0]   w_ptr_nxt;
  logic              w_others;
  logic              w_at_lim;

  rr_pick #(
    .N(N)
  ) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .any   (w_any),
    .winner(w_winner)
  );

  // Explicit wrap so non-power-of-two N stays in range.
  assign w_ptr_nxt = (w_winner == ID_W'(N - 1)) ?
                     '0 : w_winner + 1'b1;

  assign w_others = |(req & ~r_gnt);
  assign w_at_lim = (MAX_HOLD != 0) && (r_hold == HOLD_LIM);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= ARB_IDLE;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_busy    <= 1'b0;
      r_preempt <= 1'b0;
      r_ptr     <= '0;
      r_hold    <= '0;
    end else begin
      r_preempt <= 1'b0;
      unique case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_state  <= ARB_BUSY;
            r_gnt    <= N'(onehot(int'(w_winner), N));
            r_gnt_id <= w_winner;
            r_busy   <= 1'b1;
            r_hold   <= '0;
            r_ptr    <= w_ptr_nxt;
          end
        end
        ARB_BUSY: begin
          if (!req[r_gnt_id]) begin
            r_state <= ARB_IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end else if (w_at_lim && w_others) begin
            r_state   <= ARB_IDLE;
            r_gnt     <= '0;
            r_busy    <= 1'b0;
            r_preempt <= 1'b1;
          end else if (r_hold != HOLD_LIM) begin
            r_hold <= r_hold + 1'b1;
          end
        end
        default: begin
          r_state <= ARB_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign busy    = r_busy;
  assign preempt = r_preempt;

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Self-checking bench for rr_lock_arbiter (N=4, MAX_HOLD=4 and 0).
// Directed steps plus random requests against an owner-level reference model.
module tb_rr_lock_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       preempt;

  logic [3:0] req_b;
  logic [3:0] gnt_b;
  logic [1:0] gnt_id_b;
  logic       busy_b;
  logic       preempt_b;

  int total = 0;
  int bad   = 0;

  int m_owner;
  int m_hold;
  int m_ptr;
  bit m_pre;

  always #5 clock = ~clock;

  rr_lock_arbiter #(
    .N(N), .MAX_HOLD(MH)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy),
    .preempt(preempt)
  );

  rr_lock_arbiter #(
    .N(N), .MAX_HOLD(0)
  ) dut_np (
    .clock  (clock),
    .reset  (reset),
    .req    (req_b),
    .gnt    (gnt_b),
    .gnt_id (gnt_id_b),
    .busy   (busy_b),
    .preempt(preempt_b)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_hold  = 0;
    m_ptr   = 0;
    m_pre   = 1'b0;
  endtask

  // Owner-level model: who holds the resource and for how many edges.
  task automatic model_edge(input logic [3:0] r);
    bit found;
    int c;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (!found && r[c]) begin
          found   = 1'b1;
          m_owner = c;
          m_hold  = 0;
          m_ptr   = (c + 1) % N;
        end
      end
    end else if (!r[m_owner]) begin
      m_owner = -1;
    end else if (MH != 0 && m_hold >= MH - 1 &&
                 (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
      m_owner = -1;
      m_pre   = 1'b1;
    end else begin
      m_hold++;
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] e;
    e = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
    chk({tag, "_gnt"}, 32'(gnt), 32'(e));
    chk({tag, "_busy"}, 32'(busy), 32'(m_owner >= 0));
    chk({tag, "_pre"}, 32'(preempt), 32'(m_pre));
    chk({tag, "_1hot"}, 32'($countones(gnt) > 1), 32'(0));
    if (m_owner >= 0)
      chk({tag, "_id"}, 32'(gnt_id), 32'(m_owner));
  endtask

  task automatic step(input string tag, input logic [3:0] r);
    req = r;
    @(posedge clock);
    model_edge(r);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] r;
    reset = 1'b1;
    req   = 4'b0000;
    req_b = 4'b0000;
    model_reset();
    #12;
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_id", 32'(gnt_id), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_pre", 32'(preempt), 32'(0));
    @(negedge clock);
    reset = 1'b0;

    // Async reset in the middle of a grant.
    step("t1a", 4'b0010);
    chk("t1_pre_gnt", 32'(gnt), 32'(4'b0010));
    #3;
    reset = 1'b1;
    #1;
    chk("t1_async_gnt", 32'(gnt), 32'(0));
    chk("t1_async_busy", 32'(busy), 32'(0));
    chk("t1_async_pre", 32'(preempt), 32'(0));
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    repeat (3) step("t1b", 4'b0000);

    // Single requester.
    step("t2a", 4'b0001);
    chk("t2_gnt", 32'(gnt), 32'(4'b0001));
    chk("t2_id", 32'(gnt_id), 32'(0));
    repeat (5) step("t2b", 4'b0001);
    step("t2c", 4'b0000);
    chk("t2_rel", 32'(gnt), 32'(0));

    // Full contention, everyone holding.
    do_reset();
    for (int i = 1; i <= 25; i++) begin
      step("t3", 4'b1111);
      if (i == 1)  chk("t3_g0", 32'(gnt), 32'(4'b0001));
      if (i == 4)  chk("t3_g0_end", 32'(gnt), 32'(4'b0001));
      if (i == 5)  chk("t3_pre", 32'(preempt), 32'(1));
      if (i == 6)  chk("t3_g1", 32'(gnt), 32'(4'b0010));
      if (i == 11) chk("t3_g2", 32'(gnt), 32'(4'b0100));
      if (i == 16) chk("t3_g3", 32'(gnt), 32'(4'b1000));
      if (i == 21) chk("t3_wrap", 32'(gnt), 32'(4'b0001));
    end

    // Uncontested long hold, then a late contender.
    do_reset();
    repeat (12) step("t4a", 4'b0100);
    chk("t4_held", 32'(gnt), 32'(4'b0100));
    step("t4b", 4'b0110);
    chk("t4_pre", 32'(preempt), 32'(1));
    chk("t4_drop", 32'(gnt), 32'(0));
    step("t4c", 4'b0110);
    chk("t4_next", 32'(gnt), 32'(4'b0010));

    // Pointer wrap and fairness.
    do_reset();
    step("t5a", 4'b1000);
    step("t5b", 4'b0000);
    step("t5c", 4'b1001);
    chk("t5_wrap", 32'(gnt), 32'(4'b0001));
    step("t5d", 4'b0000);
    step("t5e", 4'b1001);
    chk("t5_fair", 32'(gnt), 32'(4'b1000));

    // Random traffic with sticky requests.
    do_reset();
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        r = 4'($urandom_range(0, 15));
      step("rnd", r);
    end
    step("rnd_end", 4'b0000);

    // Preemption disabled build.
    do_reset();
    req_b = 4'b1111;
    repeat (50) begin
      @(posedge clock);
      #1;
      chk("t6_gnt", 32'(gnt_b), 32'(4'b0001));
      chk("t6_pre", 32'(preempt_b), 32'(0));
      chk("t6_busy", 32'(busy_b), 32'(1));
    end
    req_b = 4'b0000;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
